// File: rtl/dbg_uart_arbiter.sv
// dbg_uart_arbiter: round-robin, message-granular sharing of one 8N1 debug UART TX pin.
// Define DBG_UART_ARB_TAG_EN to prefix each granted message with an ASCII '0'+grant tag frame.
module dbg_uart_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 434,
    localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [GW-1:0]          grant_id_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] win;
    logic [GW-1:0] cand;
    logic          found;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          msg_last;

    // First valid requester strictly after ptr, wrapping modulo NUM_REQ
    always_comb begin
        win = ptr;
        found = 1'b0;
        cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                win = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr <= GW'(NUM_REQ - 1);
            grant_id_o <= '0;
            req_ready_o <= '0;
            tx_o <= 1'b1;
            busy_o <= 1'b0;
            cnt <= '0;
            bit_cnt <= '0;
            sh <= '0;
            msg_last <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant_id_o <= win;
                    busy_o <= 1'b1;
`ifdef DBG_UART_ARB_TAG_EN
                    sh <= 8'h30 + 8'(win);
                    msg_last <= 1'b0;
                    tx_o <= 1'b0;
                    cnt <= RELOAD;
                    state <= START;
`else
                    req_ready_o <= NUM_REQ'(1) << win;
                    state <= LOAD;
`endif
                end
                LOAD: if (req_valid_i[grant_id_o]) begin
                    sh <= req_data_i[{grant_id_o, 3'b000} +: 8];
                    msg_last <= req_last_i[grant_id_o];
                    req_ready_o <= '0;
                    tx_o <= 1'b0;
                    cnt <= RELOAD;
                    state <= START;
                end
                START: if (cnt == '0) begin
                    tx_o <= sh[0];
                    cnt <= RELOAD;
                    bit_cnt <= '0;
                    state <= DATA;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DATA: if (cnt == '0) begin
                    cnt <= RELOAD;
                    if (bit_cnt == 3'd7) begin
                        tx_o <= 1'b1;
                        state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sh <= sh >> 1;
                        tx_o <= sh[1];
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                STOP: if (cnt == '0) begin
                    if (msg_last) begin
                        ptr <= grant_id_o;
                        busy_o <= 1'b0;
                        state <= IDLE;
                    end else begin
                        req_ready_o <= NUM_REQ'(1) << grant_id_o;
                        state <= LOAD;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
